// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: cache request, grant and memory port signals around the memory arbiter
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int TAG_W = 4
);
    logic              icache_req_valid;
    logic [ADDR_W-1:0] icache_req_addr;
    logic              icache_req_accepted;
    logic [TAG_W-1:0]  icache_req_tag;
    logic [DATA_W-1:0] icache_data;
    logic [TAG_W-1:0]  icache_data_tag;
    logic              dcache_req_valid;
    logic              dcache_req_store;
    logic [ADDR_W-1:0] dcache_req_addr;
    logic [DATA_W-1:0] dcache_req_data;
    logic              dcache_req_accepted;
    logic [TAG_W-1:0]  dcache_req_tag;
    logic [DATA_W-1:0] dcache_data;
    logic [TAG_W-1:0]  dcache_data_tag;
    logic [1:0]        proc2mem_command;
    logic [ADDR_W-1:0] proc2mem_addr;
    logic [DATA_W-1:0] proc2mem_data;
    logic [TAG_W-1:0]  mem2proc_transaction_tag;
    logic [DATA_W-1:0] mem2proc_data;
    logic [TAG_W-1:0]  mem2proc_data_tag;
    logic              orphan_return;

    modport slave (
        input  icache_req_valid, icache_req_addr,
        output icache_req_accepted, icache_req_tag, icache_data, icache_data_tag,
        input  dcache_req_valid, dcache_req_store, dcache_req_addr, dcache_req_data,
        output dcache_req_accepted, dcache_req_tag, dcache_data, dcache_data_tag,
        output proc2mem_command, proc2mem_addr, proc2mem_data,
        input  mem2proc_transaction_tag, mem2proc_data, mem2proc_data_tag,
        output orphan_return
    );

    modport master (
        output icache_req_valid, icache_req_addr,
        input  icache_req_accepted, icache_req_tag, icache_data, icache_data_tag,
        output dcache_req_valid, dcache_req_store, dcache_req_addr, dcache_req_data,
        input  dcache_req_accepted, dcache_req_tag, dcache_data, dcache_data_tag,
        input  proc2mem_command, proc2mem_addr, proc2mem_data,
        output mem2proc_transaction_tag, mem2proc_data, mem2proc_data_tag,
        input  orphan_return
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the memory port between icache and dcache and routes returns by tag owner
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int TAG_W = 4,
    parameter int STARVE_LIMIT = 4,
    parameter int MAX_I_OUTSTANDING = 8
) (
    input logic clock,
    input logic reset,
    mem_arbiter_if.slave bus
);
    localparam int N_TAGS = 1 << TAG_W;
    localparam int CNT_W = $clog2(MAX_I_OUTSTANDING + 1);
    localparam int ST_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] I_MAX = CNT_W'(MAX_I_OUTSTANDING);
    localparam logic [ST_W-1:0] S_MAX = ST_W'(STARVE_LIMIT);
    localparam logic [1:0] CMD_NONE = 2'd0;
    localparam logic [1:0] CMD_LOAD = 2'd1;
    localparam logic [1:0] CMD_STORE = 2'd2;

    logic [N_TAGS-1:0] owner_valid;
    logic [N_TAGS-1:0] owner_is_icache;
    logic [CNT_W-1:0]  i_out_cnt;
    logic [ST_W-1:0]   starve_cnt;
    logic              orphan;

    logic             i_elig, grant_i, grant_d, i_acc, d_acc, alloc;
    logic             ret_hit, ret_icache, ret_orphan;
    logic [TAG_W-1:0] tx_tag, rx_tag;

    // Pick a grantee, decide acceptance and look up the owner of any returning tag
    always_comb begin
        tx_tag = bus.mem2proc_transaction_tag;
        rx_tag = bus.mem2proc_data_tag;
        i_elig = !reset && bus.icache_req_valid && (i_out_cnt < I_MAX);
        grant_i = i_elig && (starve_cnt == S_MAX || !bus.dcache_req_valid);
        grant_d = !reset && bus.dcache_req_valid && !grant_i;
        i_acc = grant_i && tx_tag != '0;
        d_acc = grant_d && tx_tag != '0;
        alloc = i_acc || (d_acc && !bus.dcache_req_store);
        ret_hit = !reset && rx_tag != '0 && owner_valid[rx_tag];
        ret_icache = ret_hit && owner_is_icache[rx_tag];
        ret_orphan = !reset && rx_tag != '0 && !owner_valid[rx_tag];
    end

    // Drive the memory port, the acceptance handshakes and the routed return tags
    always_comb begin
        bus.proc2mem_command = grant_i ? CMD_LOAD :
                               grant_d ? (bus.dcache_req_store ? CMD_STORE : CMD_LOAD) : CMD_NONE;
        bus.proc2mem_addr = grant_i ? bus.icache_req_addr :
                            grant_d ? bus.dcache_req_addr : {ADDR_W{1'b0}};
        bus.proc2mem_data = (grant_d && bus.dcache_req_store) ? bus.dcache_req_data : {DATA_W{1'b0}};
        bus.icache_req_accepted = i_acc;
        bus.icache_req_tag = i_acc ? tx_tag : '0;
        bus.dcache_req_accepted = d_acc;
        bus.dcache_req_tag = d_acc ? tx_tag : '0;
        bus.icache_data = bus.mem2proc_data;
        bus.dcache_data = bus.mem2proc_data;
        bus.icache_data_tag = ret_icache ? rx_tag : '0;
        bus.dcache_data_tag = (ret_hit && !ret_icache) ? rx_tag : '0;
        bus.orphan_return = orphan;
    end

    // Owner table, icache in-flight count, starvation counter and sticky orphan flag;
    // a same-cycle return and allocation on one tag leaves the new owner in place
    always_ff @(posedge clock) begin
        if (reset) begin
            owner_valid <= '0;
            owner_is_icache <= '0;
            i_out_cnt <= '0;
            starve_cnt <= '0;
            orphan <= 1'b0;
        end else begin
            if (ret_hit) owner_valid[rx_tag] <= 1'b0;
            if (alloc) begin
                owner_valid[tx_tag] <= 1'b1;
                owner_is_icache[tx_tag] <= grant_i;
            end
            i_out_cnt <= i_out_cnt + CNT_W'(i_acc) - CNT_W'(ret_icache);
            starve_cnt <= (i_elig && !i_acc) ? ((starve_cnt == S_MAX) ? S_MAX : starve_cnt + 1'b1) : '0;
            orphan <= orphan || ret_orphan;
        end
    end

    // Protocol checks: no load on a live tag, icache count stays within range
    always_ff @(posedge clock) begin
        if (!reset) begin
            assert (!(alloc && owner_valid[tx_tag] && !(ret_hit && rx_tag == tx_tag)));
            assert (!(i_acc && !ret_icache && i_out_cnt == I_MAX));
            assert (!(ret_icache && !i_acc && i_out_cnt == '0));
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a tag-ownership model
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_tests = 0;
    int n_fail = 0;

    int own[16];
    int starve = 0;
    bit orph = 1'b0;

    mem_arbiter_if bus();

    mem_arbiter dut (
        .clock(clk),
        .reset(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive(bit iv, logic [31:0] ia, bit dv, bit ds, logic [31:0] da, logic [63:0] dd,
                         logic [3:0] tt, logic [3:0] rt, logic [63:0] rd);
        bus.icache_req_valid = iv;
        bus.icache_req_addr = ia;
        bus.dcache_req_valid = dv;
        bus.dcache_req_store = ds;
        bus.dcache_req_addr = da;
        bus.dcache_req_data = dd;
        bus.mem2proc_transaction_tag = tt;
        bus.mem2proc_data_tag = rt;
        bus.mem2proc_data = rd;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Compare every output with the ownership model, then advance model and clock one cycle
    task automatic step();
        int ic;
        bit ie, gi, gd, iacc, dacc;
        int owner;
        logic [3:0] tt, rt;
        logic [1:0] e_cmd;
        logic [31:0] e_addr;
        logic [63:0] e_pdata;
        #1;
        tt = bus.mem2proc_transaction_tag;
        rt = bus.mem2proc_data_tag;
        ic = 0;
        for (int t = 1; t < 16; t++) if (own[t] == 1) ic++;
        ie = !rst && bus.icache_req_valid && ic < 8;
        gi = ie && (starve >= 4 || !bus.dcache_req_valid);
        gd = !rst && bus.dcache_req_valid && !gi;
        iacc = gi && tt != 0;
        dacc = gd && tt != 0;
        e_cmd = gi ? 2'd1 : gd ? (bus.dcache_req_store ? 2'd2 : 2'd1) : 2'd0;
        e_addr = gi ? bus.icache_req_addr : gd ? bus.dcache_req_addr : 32'd0;
        e_pdata = (gd && bus.dcache_req_store) ? bus.dcache_req_data : 64'd0;
        owner = (rst || rt == 0) ? 0 : own[rt];
        chk("cmd", bus.proc2mem_command, e_cmd);
        chk("addr", bus.proc2mem_addr, e_addr);
        chk("pdata", bus.proc2mem_data, e_pdata);
        chk("i_acc", bus.icache_req_accepted, iacc);
        chk("i_tag", bus.icache_req_tag, iacc ? tt : 4'd0);
        chk("d_acc", bus.dcache_req_accepted, dacc);
        chk("d_tag", bus.dcache_req_tag, dacc ? tt : 4'd0);
        chk("i_data", bus.icache_data, bus.mem2proc_data);
        chk("d_data", bus.dcache_data, bus.mem2proc_data);
        chk("i_dtag", bus.icache_data_tag, owner == 1 ? rt : 4'd0);
        chk("d_dtag", bus.dcache_data_tag, owner == 2 ? rt : 4'd0);
        chk("orphan", bus.orphan_return, orph);
        if (rst) begin
            for (int t = 0; t < 16; t++) own[t] = 0;
            starve = 0;
            orph = 1'b0;
        end else begin
            if (rt != 0 && own[rt] == 0) orph = 1'b1;
            if (rt != 0) own[rt] = 0;
            if (iacc) own[tt] = 1;
            if (dacc && !bus.dcache_req_store) own[tt] = 2;
            starve = (ie && !iacc) ? (starve >= 4 ? 4 : starve + 1) : 0;
        end
        @(negedge clk);
    endtask

    initial begin
        int owned[$];
        int free[$];
        logic [3:0] rt, tt;
        for (int t = 0; t < 16; t++) own[t] = 0;
        idle();
        @(negedge clk);
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();

        drive(1, 32'h200, 1, 0, 32'h100, 0, 3, 0, 0);
        #1;
        chk("t1_d_acc", bus.dcache_req_accepted, 1);
        chk("t1_d_tag", bus.dcache_req_tag, 3);
        chk("t1_i_acc", bus.icache_req_accepted, 0);
        chk("t1_cmd", bus.proc2mem_command, 1);
        chk("t1_addr", bus.proc2mem_addr, 32'h100);
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 3, 64'h11);
        step();

        for (int k = 0; k < 6; k++) begin
            drive(1, 32'h240 + k, 1, 1, 32'h140 + k, 64'h77, 1, 0, 0);
            #1;
            chk("t2_i_acc", bus.icache_req_accepted, k == 4);
            chk("t2_d_acc", bus.dcache_req_accepted, k != 4);
            step();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
        step();

        for (int k = 1; k <= 8; k++) begin
            drive(1, 32'h1000 + k, 0, 0, 0, 0, 4'(k), 0, 0);
            step();
        end
        drive(1, 32'h2000, 0, 0, 0, 0, 9, 0, 0);
        #1;
        chk("t3_cap_acc", bus.icache_req_accepted, 0);
        chk("t3_cap_cmd", bus.proc2mem_command, 0);
        step();
        drive(1, 32'h2000, 0, 0, 0, 0, 9, 2, 64'h22);
        #1;
        chk("t3_ret2", bus.icache_data_tag, 2);
        step();
        drive(1, 32'h2000, 0, 0, 0, 0, 9, 0, 0);
        #1;
        chk("t3_after", bus.icache_req_accepted, 1);
        step();
        for (int k = 1; k <= 9; k++) begin
            if (k == 2) continue;
            drive(0, 0, 0, 0, 0, 0, 0, 4'(k), 64'(k));
            step();
        end

        drive(1, 32'h500, 0, 0, 0, 0, 5, 0, 0);
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 5, 64'hDEADBEEF);
        #1;
        chk("t4_i_dtag", bus.icache_data_tag, 5);
        chk("t4_d_dtag", bus.dcache_data_tag, 0);
        chk("t4_data", bus.icache_data, 64'hDEADBEEF);
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 5, 64'h1);
        #1;
        chk("t4_orph_i", bus.icache_data_tag, 0);
        chk("t4_orph_d", bus.dcache_data_tag, 0);
        step();
        idle();
        #1;
        chk("t4_orphan", bus.orphan_return, 1);
        step();

        drive(1, 32'h700, 0, 0, 0, 0, 7, 0, 0);
        step();
        drive(0, 0, 1, 0, 32'h300, 0, 7, 7, 64'h7);
        #1;
        chk("t5_i_dtag", bus.icache_data_tag, 7);
        chk("t5_d_acc", bus.dcache_req_accepted, 1);
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 7, 64'h8);
        #1;
        chk("t5_d_dtag", bus.dcache_data_tag, 7);
        chk("t5_i_dtag", bus.icache_data_tag, 0);
        step();

        drive(0, 0, 1, 1, 32'h400, 64'h55, 4, 0, 0);
        #1;
        chk("t6_cmd", bus.proc2mem_command, 2);
        chk("t6_pdata", bus.proc2mem_data, 64'h55);
        step();
        drive(1, 32'h600, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("t6_rej_cmd", bus.proc2mem_command, 1);
        chk("t6_rej_acc", bus.icache_req_accepted, 0);
        chk("t6_rej_tag", bus.icache_req_tag, 0);
        step();
        drive(1, 32'h600, 0, 0, 0, 0, 6, 0, 0);
        step();
        rst = 1'b1;
        drive(1, 32'h600, 1, 0, 32'h610, 64'h9, 2, 6, 64'h3);
        #1;
        chk("t6_rst_cmd", bus.proc2mem_command, 0);
        chk("t6_rst_addr", bus.proc2mem_addr, 0);
        chk("t6_rst_dacc", bus.dcache_req_accepted, 0);
        chk("t6_rst_idtag", bus.icache_data_tag, 0);
        step();
        idle();
        step();
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 6, 64'h6);
        #1;
        chk("t6_drop", bus.icache_data_tag, 0);
        chk("t6_orph_clr", bus.orphan_return, 0);
        step();
        for (int k = 1; k <= 9; k++) begin
            drive(1, 32'h800 + k, 0, 0, 0, 0, 4'(k), 0, 0);
            #1;
            chk("t6_refill", bus.icache_req_accepted, k <= 8);
            step();
        end
        rst = 1'b1;
        idle();
        step();
        rst = 1'b0;

        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 399) == 0);
            owned.delete();
            free.delete();
            for (int t = 1; t < 16; t++) if (own[t] != 0) owned.push_back(t);
            rt = (owned.size() > 0 && $urandom_range(0, 1) == 1) ?
                 4'(owned[$urandom_range(0, owned.size() - 1)]) : 4'd0;
            for (int t = 1; t < 16; t++) if (own[t] == 0 || t == int'(rt)) free.push_back(t);
            tt = (free.size() == 0 || $urandom_range(0, 7) == 0) ?
                 4'd0 : 4'(free[$urandom_range(0, free.size() - 1)]);
            drive($urandom_range(0, 2) != 0, $urandom, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 2) == 0, $urandom, {$urandom, $urandom},
                  tt, rt, {$urandom, $urandom});
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single processor-memory port between the icache subsystem (demand misses and prefetches) and the dcache (loads and stores).
- Picks one requester per cycle. Data has fixed priority, with a starvation override for instruction requests.
- Records which requester owns each outstanding memory tag and routes returned data and tags back to that requester.
- Caps instruction-side outstanding requests so prefetching cannot take every memory tag.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 64, memory block width (MEM_BLOCK).
- TAG_W, 4, memory tag width. Tag 0 means "none"; usable tags are 1..2^TAG_W-1.
- STARVE_LIMIT, 4, number of consecutive icache losses that forces an icache grant.
- MAX_I_OUTSTANDING, 8, maximum number of icache loads in flight.

Ports:
- clock in 1: system clock.
- reset in 1: synchronous, active-high; clears all state.
- icache_req_valid in 1: icache load request.
- icache_req_addr in ADDR_W: icache block address.
- icache_req_accepted out 1: the request was issued and memory gave it a nonzero tag this cycle.
- icache_req_tag out TAG_W: tag given to the icache request; 0 when not accepted.
- icache_data out DATA_W: returned block, passed straight through from memory.
- icache_data_tag out TAG_W: return tag when the icache owns it, else 0.
- dcache_req_valid in 1: dcache request.
- dcache_req_store in 1: 1 means store, 0 means load.
- dcache_req_addr in ADDR_W: dcache address.
- dcache_req_data in DATA_W: store data.
- dcache_req_accepted out 1: dcache request was accepted.
- dcache_req_tag out TAG_W: tag given to the dcache request.
- dcache_data out DATA_W: returned block, passed straight through.
- dcache_data_tag out TAG_W: return tag when the dcache owns it, else 0.
- proc2mem_command out 2: 0 = NONE, 1 = LOAD, 2 = STORE.
- proc2mem_addr out ADDR_W: address of the granted request.
- proc2mem_data out DATA_W: store data; 0 unless the command is STORE.
- mem2proc_transaction_tag in TAG_W: same-cycle tag response; 0 means rejected.
- mem2proc_data in DATA_W: returned block.
- mem2proc_data_tag in TAG_W: tag of the returned block; 0 means no return.
- orphan_return out 1: sticky; a return arrived for a tag with no owner.

Behaviour:

State:
- owner_valid[2^TAG_W], owner_is_icache[2^TAG_W].
- i_out_cnt: counter of icache loads in flight, width $clog2(MAX_I_OUTSTANDING+1).
- starve_cnt: saturates at STARVE_LIMIT.
- orphan flag.

Reset:
- All state is cleared.
- Every output is 0 in the reset cycle and the cycle after it, unless an input drives it combinationally.
- proc2mem_command = NONE.
- A reset in the middle of operation drops every in-flight owner. Later returns of those tags raise orphan_return.

Eligibility:
- icache is eligible when icache_req_valid is high and i_out_cnt < MAX_I_OUTSTANDING.
- dcache is eligible when dcache_req_valid is high.

Grant (combinational, zero latency):
- If starve_cnt == STARVE_LIMIT and the icache is eligible, the icache is granted.
- Otherwise, if the dcache is eligible, the dcache is granted.
- Otherwise, if the icache is eligible, the icache is granted.
- Otherwise nothing is granted and the command is NONE.
- The granted request drives proc2mem_command, proc2mem_addr and proc2mem_data.

Accept:
- A request is accepted when it is granted and mem2proc_transaction_tag != 0.
- The accepted requester sees accepted = 1 and req_tag = the transaction tag.
- The other requester sees accepted = 0 and req_tag = 0.
- A rejected grant (tag 0) is not accepted. The requester holds its request and retries; the arbiter keeps no record of it.

starve_cnt update:
- Increments, saturating, when the icache is eligible and is not accepted.
- Resets to 0 when an icache request is accepted, or when the icache is not eligible.

Owner allocation:
- Only accepted loads allocate: owner_valid[t] <= 1 and owner_is_icache[t] <= the grantee is the icache.
- Accepted stores do not allocate; no data returns for stores.
- An accepted icache load increments i_out_cnt.

Return routing:
- When mem2proc_data_tag = r != 0 and owner_valid[r] is set, r is forwarded on the owner's data_tag in the same cycle.
- The entry is then cleared. If the owner was the icache, i_out_cnt decrements.
- If owner_valid[r] is not set, the return is dropped, both data_tags stay 0, and orphan_return is set.
- The data outputs always mirror mem2proc_data; only the tag outputs are gated.

Simultaneous events:
- A return and an acceptance can occur in the same cycle, including on the same tag, because memory may reissue a freed tag.
- Routing uses the owner held before the update. The new allocation then overwrites the entry, so owner_valid stays 1 with the new owner.
- An icache return and an icache acceptance in the same cycle leave i_out_cnt unchanged.
- An accepted load on a tag that is already valid is a protocol error: assertion only, and the new owner overwrites.

Boundary conditions:
- While i_out_cnt == MAX_I_OUTSTANDING, the icache is never granted and starve_cnt holds at 0.
- i_out_cnt never underflows or overflows; both are guarded by assertions.

Test Plan:
- Both requesters valid, dcache load at 0x100, icache at 0x200, memory tag 3 → dcache_req_accepted=1, dcache_req_tag=3, icache_req_accepted=0, proc2mem_command=1, proc2mem_addr=0x100.
- dcache valid continuously; icache valid; every memory tag nonzero → dcache granted for 4 cycles, icache granted in the 5th cycle, starve_cnt returns to 0.
- Eight icache loads accepted on tags 1..8 → ninth icache request not granted; return on tag 2 → icache_data_tag=2; next icache request is granted.
- Icache owns tag 5; mem2proc_data_tag=5 with data 0xDEADBEEF → icache_data_tag=5, dcache_data_tag=0; entry cleared. A second return on tag 5 → orphan_return=1, both data_tags 0.
- Return on tag 7 (icache) while a dcache load is accepted on tag 7 → icache_data_tag=7 this cycle; a later return on tag 7 → dcache_data_tag=7.
- Dcache store with data 0x55 accepted, then memory tag 0 on an icache grant → proc2mem_data=0x55 on the STORE cycle; no owner entry; icache_req_accepted=0 and i_out_cnt unchanged. Reset mid-stream → all outputs 0 and i_out_cnt=0.
